sm83_inertial_delay: RTL and testbench

SM83_INERTIAL_DELAY -- requirements
Module: sm83_inertial_delay

---
 rtl/sm83_inertial_delay.sv | 122 ++++++++++++
 tb/tb_sm83_inertial_delay.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_inertial_delay.sv
// rtl/sm83_inertial_delay.sv - per-channel inertial delay with rise/fall timing and glitch rejection
module sm83_inertial_delay #(
    parameter int              CH      = 8,
    parameter int              CW      = 6,
    parameter int              T_PLH   = 1,
    parameter int              T_PHL   = 1,
    parameter int              T_MIN   = 1,
    parameter logic [CH-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nodelay,
    input  logic [CH-1:0] din,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_plh,
    input  logic [CW-1:0] cfg_phl,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] busy
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // The floor is never below one tick, so a zero config cannot underflow the counter
    localparam int            TMIN_EFF = (T_MIN < 1) ? 1 : T_MIN;
    localparam logic [CW-1:0] TMIN_W   = CW'(TMIN_EFF);
    localparam logic [CW-1:0] PLH_RST  = CW'(T_PLH);
    localparam logic [CW-1:0] PHL_RST  = CW'(T_PHL);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0]          plh;
    logic [CW-1:0]          phl;
    logic [CW-1:0]          d_rise;
    logic [CW-1:0]          d_fall;
    logic [CH-1:0][CW-1:0]  d_eff;
    state_t                 state [CH];
    logic [CW-1:0]          cnt   [CH];
    logic [CH-1:0]          q;
    logic [CH-1:0]          pend;

    // Configuration registers; reset wins over a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            plh <= PLH_RST;
            phl <= PHL_RST;
        end else if (cfg_we) begin
            plh <= cfg_plh;
            phl <= cfg_phl;
        end
    end

    // Effective rise/fall delays with the floor applied
    always_comb begin
        d_rise = (plh > TMIN_W) ? plh : TMIN_W;
        d_fall = (phl > TMIN_W) ? phl : TMIN_W;
    end

    // Per-channel delay selection: a differing din of 1 is a rise, of 0 a fall
    always_comb begin
        d_eff = '0;
        for (int i = 0; i < CH; i++) begin
            d_eff[i] = din[i] ? d_rise : d_fall;
        end
    end

    // Per-channel IDLE/PEND machine; the counter latches the delay at PEND entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (reset) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                q[i]     <= RST_VAL[i];
            end else begin
                case (state[i])
                    IDLE: begin
                        if (din[i] != q[i]) begin
                            if (d_eff[i] == ONE) begin
                                q[i] <= din[i];
                            end else begin
                                cnt[i]   <= d_eff[i] - ONE;
                                state[i] <= PEND;
                            end
                        end
                    end
                    PEND: begin
                        if (din[i] == q[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == ONE) begin
                            q[i]     <= din[i];
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - ONE;
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Pending flags straight from the registered state
    always_comb begin
        pend = '0;
        for (int i = 0; i < CH; i++) begin
            pend[i] = (state[i] == PEND);
        end
    end

    // Bypass exposes din directly while the machines keep running underneath
    always_comb begin
        dout = nodelay ? din : q;
        busy = nodelay ? '0 : pend;
    end

endmodule

// File: tb/tb_sm83_inertial_delay.sv
// tb/tb_sm83_inertial_delay.sv - randomized and directed checks against a deadline-based model
module tb_sm83_inertial_delay;

    logic       clk = 1'b0;
    logic       reset;
    logic       nodelay;
    logic [7:0] din;
    logic       cfg_we;
    logic [5:0] cfg_plh;
    logic [5:0] cfg_phl;
    logic [7:0] dout_a, busy_a, dout_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm83_inertial_delay u_dut_a (
        .clk(clk), .reset(reset), .nodelay(nodelay), .din(din),
        .cfg_we(cfg_we), .cfg_plh(cfg_plh), .cfg_phl(cfg_phl),
        .dout(dout_a), .busy(busy_a)
    );

    sm83_inertial_delay #(
        .CH(8), .CW(6), .T_PLH(3), .T_PHL(2), .T_MIN(2), .RST_VAL(8'hA5)
    ) u_dut_b (
        .clk(clk), .reset(reset), .nodelay(nodelay), .din(din),
        .cfg_we(cfg_we), .cfg_plh(cfg_plh), .cfg_phl(cfg_phl),
        .dout(dout_b), .busy(busy_b)
    );

    // Model: a pending edge has an absolute deadline edge number; output flips when reached
    int         def_plh [2] = '{1, 3};
    int         def_phl [2] = '{1, 2};
    int         tmin    [2] = '{1, 2};
    logic [7:0] rstv    [2] = '{8'h00, 8'hA5};
    logic [7:0] mq      [2];
    logic [7:0] mpend   [2];
    int         mdead   [2][8];
    int         mplh    [2];
    int         mphl    [2];
    int         edge_no = 0;
    bit         model_valid = 0;

    function automatic int max3(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? m : 1;
    endfunction

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 8; c++) begin
                if (reset) begin
                    mq[n][c]    = rstv[n][c];
                    mpend[n][c] = 1'b0;
                end else if (din[c] != mq[n][c]) begin
                    if (!mpend[n][c]) begin
                        mdead[n][c] = edge_no - 1 +
                            (din[c] ? max3(mplh[n], tmin[n]) : max3(mphl[n], tmin[n]));
                        mpend[n][c] = 1'b1;
                    end
                    if (edge_no == mdead[n][c]) begin
                        mq[n][c]    = din[c];
                        mpend[n][c] = 1'b0;
                    end
                end else begin
                    mpend[n][c] = 1'b0;
                end
            end
            if (reset) begin
                mplh[n] = def_plh[n];
                mphl[n] = def_phl[n];
            end else if (cfg_we) begin
                mplh[n] = int'(cfg_plh);
                mphl[n] = int'(cfg_phl);
            end
        end
        if (reset) model_valid = 1;
        edge_no++;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (model_valid) begin
            chk("a_dout", dout_a, nodelay ? din : mq[0]);
            chk("a_busy", busy_a, nodelay ? 8'h00 : mpend[0]);
            chk("b_dout", dout_b, nodelay ? din : mq[1]);
            chk("b_busy", busy_b, nodelay ? 8'h00 : mpend[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [5:0] p, input logic [5:0] f);
        cfg_we = 1'b1; cfg_plh = p; cfg_phl = f;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; nodelay = 1'b0; din = 8'h00;
        cfg_we = 1'b0; cfg_plh = '0; cfg_phl = '0;
        step();
        chk("rst_a_dout", dout_a, 8'h00);
        chk("rst_a_busy", busy_a, 8'h00);
        chk("rst_b_dout", dout_b, 8'hA5);
        reset = 1'b0;

        // plain rise delay of 3
        write_cfg(6'd3, 6'd4);
        din[0] = 1'b1;
        step();
        chk("rise_e10_busy", busy_a & 8'h01, 8'h01);
        chk("rise_e10_dout", dout_a & 8'h01, 8'h00);
        step();
        chk("rise_e11_busy", busy_a & 8'h01, 8'h01);
        chk("rise_e11_dout", dout_a & 8'h01, 8'h00);
        step();
        chk("rise_e12_dout", dout_a & 8'h01, 8'h01);
        chk("rise_e12_busy", busy_a & 8'h01, 8'h00);

        // two-cycle high pulse is rejected
        din[1] = 1'b1;
        step();
        chk("glitch_busy0", busy_a & 8'h02, 8'h02);
        step();
        chk("glitch_busy1", busy_a & 8'h02, 8'h02);
        din[1] = 1'b0;
        step();
        chk("glitch_busy_drop", busy_a & 8'h02, 8'h00);
        chk("glitch_dout", dout_a & 8'h02, 8'h00);

        // zero config: one tick on A, floor of two on B
        write_cfg(6'd0, 6'd0);
        din[3] = 1'b1;
        step();
        chk("zero_a_dout", dout_a & 8'h08, 8'h08);
        chk("zero_b_busy", busy_b & 8'h08, 8'h08);
        chk("zero_b_dout0", dout_b & 8'h08, 8'h00);
        step();
        chk("zero_b_dout1", dout_b & 8'h08, 8'h08);

        // reconfigure during a pending rise
        write_cfg(6'd5, 6'd5);
        din[4] = 1'b1;
        step();
        step();
        cfg_we = 1'b1; cfg_plh = 6'd1; cfg_phl = 6'd1;
        step();
        cfg_we = 1'b0;
        chk("recfg_e2", dout_a & 8'h10, 8'h00);
        step();
        chk("recfg_e3", dout_a & 8'h10, 8'h00);
        step();
        chk("recfg_e4", dout_a & 8'h10, 8'h10);
        din[5] = 1'b1;
        step();
        chk("recfg_next", dout_a & 8'h20, 8'h20);

        // reset while every channel is pending a rise
        din = 8'h00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        write_cfg(6'd6, 6'd6);
        din = 8'hFF;
        step();
        step();
        chk("pend_all_busy", busy_a, 8'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstpend_a_dout", dout_a, 8'h00);
        chk("rstpend_a_busy", busy_a, 8'h00);
        chk("rstpend_b_dout", dout_b, 8'hA5);
        chk("rstpend_b_busy", busy_b, 8'h00);
        step();
        chk("rst_plh_restored", dout_a, 8'hFF);

        // bypass
        nodelay = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            #1;
            chk("bypass_dout", dout_a, din);
            chk("bypass_busy", busy_a | busy_b, 8'h00);
            step();
        end
        din = 8'h3C;
        step();
        step();
        din = 8'hC3;
        #1;
        chk("bypass_live", dout_a, 8'hC3);
        nodelay = 1'b0;
        #1;
        chk("bypass_exit_q", dout_a, 8'h3C);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            din     = din ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cfg_we  = ($urandom_range(0, 19) == 0);
            cfg_plh = 6'($urandom_range(0, 7));
            cfg_phl = 6'($urandom_range(0, 7));
            nodelay = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; cfg_we = 1'b0; nodelay = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
